// File: rtl/fetch_unit.sv
// fetch_unit: PC-owning instruction fetch front end with in-order response FIFO; `FETCH_BYPASS_EN adds a response-to-decode bypass
module fetch_unit #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr_data,
  output logic [XLEN-1:0] instr_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [XLEN-1:0] fetch_pc, rsp_pc;
  logic [CW-1:0] in_flight, stale, count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];
  logic req_fire, rsp_take, drop, bypass, push, pop;
  assign imem_req_valid = !rst && ({1'b0, count} + {1'b0, in_flight} < (CW+1)'(DEPTH));
  assign imem_req_addr = fetch_pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  // responses with nothing outstanding are ignored, so stray data after reset is harmless
  assign rsp_take = imem_rsp_valid && in_flight != '0;
  assign drop = rsp_take && stale != '0;
`ifdef FETCH_BYPASS_EN
  assign bypass = count == '0 && stale == '0 && rsp_take && !redirect_valid;
`else
  assign bypass = 1'b0;
`endif
  assign instr_valid = count != '0 || bypass;
  assign instr_data = bypass ? imem_rsp_data : data_mem[rd_ptr];
  assign instr_pc = bypass ? rsp_pc : pc_mem[rd_ptr];
  assign pop = count != '0 && instr_ready;
  assign push = rsp_take && !drop && !(bypass && instr_ready);
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC & ~XLEN'(3);
      rsp_pc <= RESET_PC & ~XLEN'(3);
      in_flight <= '0;
      stale <= '0;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      in_flight <= in_flight + CW'(req_fire) - CW'(rsp_take);
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        rsp_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        stale <= in_flight + CW'(req_fire) - CW'(rsp_take);
        count <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp_take && !drop) rsp_pc <= rsp_pc + XLEN'(4);
        stale <= stale - CW'(drop);
        count <= count + CW'(push) - CW'(pop);
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr] <= rsp_pc;
      data_mem[wr_ptr] <= imem_rsp_data;
    end
  end
endmodule
